// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator.
// Takes WIDTH per-bit e/g/l triples from a 1-bit comparator cell, one per
// bit_valid cycle, and produces a one-hot word verdict with a done pulse.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; outputs hold the last verdict
// S_COMPARE | accepting triples on bit_valid; busy=1
// S_DONE    | one cycle; done=1, verdict visible; start here restarts
module serial_mag_comparator #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_valid,
    input  logic e_in,
    input  logic g_in,
    input  logic l_in,
    output logic busy,
    output logic done,
    output logic e,
    output logic g,
    output logic l,
    output logic err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        V_EQ = 2'd0,
        V_GT = 2'd1,
        V_LT = 2'd2
    } verdict_t;

    state_t        state;
    state_t        state_nxt;
    verdict_t      verdict;
    verdict_t      verdict_nxt;
    logic [CW-1:0] count;
    logic          decided;
    logic          err_nxt;
    logic          start_acc;
    logic          accept;
    logic          last_bit;
    logic          legal;
    logic          take_bit;

    // start is only honoured when no comparison is running
    assign start_acc = start && ((state == S_IDLE) || (state == S_DONE));
    assign accept    = (state == S_COMPARE) && bit_valid;
    assign last_bit  = accept && (count == CW'(WIDTH - 1));
    // exactly one of three: odd number set, but not all three
    assign legal     = (e_in ^ g_in ^ l_in) && !(e_in && g_in && l_in);
    // MSB first: first unequal bit decides; LSB first: last unequal bit wins
    assign take_bit  = accept && !e_in && (!MSB_FIRST || !decided);

    // running verdict and sticky error including the triple taken this cycle
    always_comb begin
        verdict_nxt = verdict;
        err_nxt     = err;
        if (take_bit) begin
            verdict_nxt = g_in ? V_GT : V_LT;
        end
        if (accept && !legal) begin
            err_nxt = 1'b1;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_COMPARE;
                end
            end
            S_COMPARE: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = start ? S_COMPARE : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // bit counter, running verdict, error flag and registered word verdict
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            verdict <= V_EQ;
            decided <= 1'b0;
            err     <= 1'b0;
            e       <= 1'b0;
            g       <= 1'b0;
            l       <= 1'b0;
        end else if (start_acc) begin
            count   <= '0;
            verdict <= V_EQ;
            decided <= 1'b0;
            err     <= 1'b0;
            e       <= 1'b0;
            g       <= 1'b0;
            l       <= 1'b0;
        end else if (accept) begin
            count   <= count + CW'(1);
            verdict <= verdict_nxt;
            err     <= err_nxt;
            if (take_bit) begin
                decided <= 1'b1;
            end
            if (last_bit) begin
                // a corrupted comparison reports no verdict at all
                e <= !err_nxt && (verdict_nxt == V_EQ);
                g <= !err_nxt && (verdict_nxt == V_GT);
                l <= !err_nxt && (verdict_nxt == V_LT);
            end
        end
    end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator: a per-cycle vector table driven
// into MSB-first and LSB-first WIDTH=4 instances, plus WIDTH=1 sequences.
module tb_serial_mag_comparator;

    logic clk = 1'b0;
    logic rst, start, bit_valid, e_in, g_in, l_in;

    logic busy_m, done_m, e_m, g_m, l_m, err_m;
    logic busy_l, done_l, e_l, g_l, l_l, err_l;
    logic busy_1, done_1, e_1, g_1, l_1, err_1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_mag_comparator #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
        .e_in(e_in), .g_in(g_in), .l_in(l_in),
        .busy(busy_m), .done(done_m), .e(e_m), .g(g_m), .l(l_m), .err(err_m)
    );

    serial_mag_comparator #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
        .e_in(e_in), .g_in(g_in), .l_in(l_in),
        .busy(busy_l), .done(done_l), .e(e_l), .g(g_l), .l(l_l), .err(err_l)
    );

    serial_mag_comparator #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
        .e_in(e_in), .g_in(g_in), .l_in(l_in),
        .busy(busy_1), .done(done_1), .e(e_1), .g(g_1), .l(l_1), .err(err_1)
    );

    // inputs {rst,start,bit_valid,e_in,g_in,l_in}
    // expected after the edge {busy,done,e,g,l,err}
    typedef struct {
        logic [5:0] in;
        logic [5:0] exp_m;
        logic [5:0] exp_l;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [5:0] in, logic [5:0] em, logic [5:0] el);
        vec_t v;
        v.in    = in;
        v.exp_m = em;
        v.exp_l = el;
        return v;
    endfunction

    task automatic drive(logic [5:0] in);
        @(negedge clk);
        {rst, start, bit_valid, e_in, g_in, l_in} = in;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [5:0] act, logic [5:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got busy,done,e,g,l,err=%b expected %b", name, act, exp);
        end
    endtask

    initial begin
        {rst, start, bit_valid, e_in, g_in, l_in} = 6'b100000;

        // T1: MSB first e,e,g,e -> g, done 6 cycles after start
        tbl.push_back(mk(6'b010000, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001100, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001100, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001010, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001100, 6'b010100, 6'b010100));
        tbl.push_back(mk(6'b000000, 6'b000100, 6'b000100));
        // T3: e,l,g,e -> MSB first says l, LSB first says g
        tbl.push_back(mk(6'b010000, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001100, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001001, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001010, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001100, 6'b010010, 6'b010100));
        tbl.push_back(mk(6'b000000, 6'b000010, 6'b000100));
        // T2: equal with gaps; valid in start cycle and in DONE ignored
        tbl.push_back(mk(6'b011010, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001100, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b000000, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b000000, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001100, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001100, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001100, 6'b011000, 6'b011000));
        tbl.push_back(mk(6'b001010, 6'b001000, 6'b001000));
        // T4: illegal triple on bit 2 -> err, no verdict; next start clears
        tbl.push_back(mk(6'b010000, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001100, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001110, 6'b100001, 6'b100001));
        tbl.push_back(mk(6'b001001, 6'b100001, 6'b100001));
        tbl.push_back(mk(6'b001100, 6'b010001, 6'b010001));
        tbl.push_back(mk(6'b000000, 6'b000001, 6'b000001));
        // T5: reset after 2 accepts aborts, fresh comparison gives l
        tbl.push_back(mk(6'b010000, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001010, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001010, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b101100, 6'b000000, 6'b000000));
        tbl.push_back(mk(6'b000000, 6'b000000, 6'b000000));
        tbl.push_back(mk(6'b010000, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001001, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001100, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001100, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001100, 6'b010010, 6'b010010));
        tbl.push_back(mk(6'b000000, 6'b000010, 6'b000010));
        // T6: A (g) then B (l) back to back; starts during COMPARE ignored
        tbl.push_back(mk(6'b010000, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001010, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001100, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001100, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b011100, 6'b010100, 6'b010100));
        tbl.push_back(mk(6'b010000, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001100, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b011100, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b011001, 6'b100000, 6'b100000));
        tbl.push_back(mk(6'b001100, 6'b010010, 6'b010010));
        tbl.push_back(mk(6'b000000, 6'b000010, 6'b000010));

        // reset state
        drive(6'b100000);
        drive(6'b100000);
        check("reset_msb", {busy_m, done_m, e_m, g_m, l_m, err_m}, 6'b000000);
        check("reset_lsb", {busy_l, done_l, e_l, g_l, l_l, err_l}, 6'b000000);
        check("reset_w1",  {busy_1, done_1, e_1, g_1, l_1, err_1}, 6'b000000);
        drive(6'b000000);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].in);
            check($sformatf("vec%0d_msb", i), {busy_m, done_m, e_m, g_m, l_m, err_m}, tbl[i].exp_m);
            check($sformatf("vec%0d_lsb", i), {busy_l, done_l, e_l, g_l, l_l, err_l}, tbl[i].exp_l);
        end

        // WIDTH=1: a single l triple completes the comparison
        drive(6'b100000);
        drive(6'b010000);
        check("w1_start", {busy_1, done_1, e_1, g_1, l_1, err_1}, 6'b100000);
        drive(6'b001001);
        check("w1_done_l", {busy_1, done_1, e_1, g_1, l_1, err_1}, 6'b010010);
        drive(6'b000000);
        check("w1_hold_l", {busy_1, done_1, e_1, g_1, l_1, err_1}, 6'b000010);

        // WIDTH=1: gap before the triple, bounded wait for done
        drive(6'b010000);
        drive(6'b000000);
        drive(6'b000000);
        check("w1_stall", {busy_1, done_1, e_1, g_1, l_1, err_1}, 6'b100000);
        drive(6'b001010);
        begin
            int budget = 10;
            while (!done_1 && budget > 0) begin
                drive(6'b000000);
                budget--;
            end
            vectors++;
            if (!done_1) begin
                miscompares++;
                $display("FAIL w1_done_timeout: done=%b after wait, expected 1", done_1);
            end else begin
                check("w1_done_g", {busy_1, done_1, e_1, g_1, l_1, err_1}, 6'b010100);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
Bit-serial magnitude comparator. It sits directly downstream of the 1-bit comparator stage (per-bit e/g/l triple). It accumulates WIDTH per-bit results, one per valid cycle, and produces the word-level equal/greater/less verdict with a done pulse. The 1-bit cell can then be reused serially instead of building a WIDTH-bit combinational comparator.

Parameters:
WIDTH, 8, number of bit triples per comparison (>=1)
MSB_FIRST, 1, 1 = triples arrive MSB first; 0 = LSB first

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  begin a new comparison (pulse)
bit_valid  input  1  e_in/g_in/l_in carry one bit result this cycle
e_in  input  1  bit equal (a==b) from 1-bit comparator
g_in  input  1  bit greater (a>b)
l_in  input  1  bit less (a<b)
busy  output  1  comparison in progress
done  output  1  one-cycle pulse: verdict valid
e  output  1  word equal
g  output  1  word greater
l  output  1  word less
err  output  1  a non-one-hot triple was received in the current comparison

Behaviour:
- Reset (rst=1 at clk edge): state IDLE. busy=done=e=g=l=err=0. Internal count and decided flag are cleared. Reset mid-comparison aborts with no done pulse.
- States:
  - IDLE: busy=0. start=1 -> COMPARE.
  - COMPARE: busy=1. The block accepts a triple on each cycle with bit_valid=1. After the WIDTH-th accepted triple -> DONE.
  - DONE: one cycle; done=1, busy=0. The next state is IDLE, or COMPARE if start=1 in this cycle (back-to-back allowed).
- On accepted start: count=0, running verdict = equal, decided=0, err=0. Outputs e/g/l clear to 0 on the same edge.
- Accepting a triple: count increments; count width is clog2(WIDTH+1).
  - MSB_FIRST=1: the first triple with e_in=0 fixes the verdict (g_in or l_in) and sets decided. Later triples are counted but do not change the verdict.
  - MSB_FIRST=0: every triple with e_in=0 overwrites the verdict, so the last non-equal bit wins.
  - No non-equal triple -> verdict equal.
- One-hot check: a triple counts as legal only if exactly one of e_in/g_in/l_in is 1. An illegal triple sets err, which is sticky until the next accepted start; the triple still counts toward WIDTH.
- Verdict registration: on entry to DONE, e/g/l load the verdict, one-hot. If err=1 they load e=g=l=0. e/g/l and err hold until the next accepted start or reset.
- Latency: done is high in the cycle after the edge that accepted the WIDTH-th triple. Minimum start-to-done is WIDTH+1 cycles.
- Gaps: bit_valid=0 in COMPARE stalls; no state change.
- Ignored inputs:
  - start in COMPARE.
  - bit_valid in IDLE or DONE.
  - bit_valid in the same cycle start is accepted (the first triple is taken on the following cycles).
- WIDTH=1: one accepted triple -> DONE.

Test Plan:
1. WIDTH=4, MSB_FIRST=1, a=1011 b=1001: triples e,e,g,e on 4 consecutive cycles -> done on cycle 6 after start (start + 4 accepts + done); g=1, e=l=0, err=0.
2. WIDTH=4, MSB_FIRST=1, a=b=0110: four e triples with bit_valid gaps (valid, idle, idle, valid, valid, valid) -> done one cycle after the 4th accept; e=1; busy=1 throughout the gaps.
3. WIDTH=4, MSB_FIRST=0, a=0101 b=0011, LSB first: triples e,l,g,e -> g=1 (bit 2 wins). Same stimulus with MSB_FIRST=1 -> l=1 (first non-equal wins).
4. Illegal triple (e_in=g_in=1) on bit 2 of 4 -> done still pulses after 4 accepts; err=1, e=g=l=0. The next start clears err.
5. rst asserted after 2 of 4 accepts -> no done; all outputs 0 next cycle. A fresh comparison afterwards completes normally.
6. start held high in the DONE cycle of comparison A; comparison B (a<b) follows -> A's verdict visible with done. B proceeds without passing through IDLE, and B ends with l=1. start pulses during B's COMPARE are ignored.
